switch_nport: RTL
=================

// Module: switch_nport
// PURPOSE
//  Parametrised N-port packet switch; successor to the 2-port address switch.
//  Routes each accepted (addr, data) word by address to one of NUM_PORTS output ports,
//  each port buffered by its own FIFO with valid/ready flow control.
//  Adds input backpressure, broadcast mode and a drop counter for unmapped addresses.
//  Sits between the packet source and the per-port consumers in the switch subsystem.
// PARAMETERS
//  ADDR_W      8   address width
//  DATA_W      16  data width
//  NUM_PORTS   3   output port count, 2..2**ADDR_W-1
//  FIFO_DEPTH  4   entries per port FIFO, power of two, >=2
//  BCAST_EN    1   1: addr all-ones broadcasts to every port; 0: treated as a normal addr
//  PSEL_W      derived, $clog2(NUM_PORTS), not overridable
// PORTS
//  clk       in   1                 clock, all logic on rising edge
//  rst       in   1                 synchronous reset, active-high
//  vld       in   1                 input word valid
//  rdy       out  1                 input can accept; transfer when vld && rdy
//  addr      in   ADDR_W            destination address
//  data      in   DATA_W            payload
//  out_vld   out  NUM_PORTS         per-port head valid (bit i = port i)
//  out_rdy   in   NUM_PORTS         per-port consumer ready
//  out_addr  out  NUM_PORTS*ADDR_W  per-port head addr, port i at [i*ADDR_W +: ADDR_W]
//  out_data  out  NUM_PORTS*DATA_W  per-port head data, port i at [i*DATA_W +: DATA_W]
//  drop_cnt  out  16                count of words dropped as unmapped, saturating
// BEHAVIOUR
//  Reset (rst=1 at clk edge): all FIFOs emptied, out_vld=0, out_addr=0, out_data=0,
//   drop_cnt=0; rdy forced 0 while rst is high. No push or pop during reset.
//  Decode: sel = addr[ADDR_W-1 -: PSEL_W].
//   BCAST_EN && addr == all-ones: broadcast. Otherwise sel < NUM_PORTS: unicast to port sel.
//   Otherwise: unmapped.
//  rdy (combinational from addr and registered full flags):
//   unicast: !full[sel]; broadcast: no FIFO full; unmapped: 1.
//  Transfer (vld && rdy):
//   unicast: push {addr,data} into FIFO sel. Broadcast: push into every FIFO, same cycle.
//   Unmapped: discard; drop_cnt += 1, holds at 16'hFFFF.
//  vld && !rdy: nothing pushed. The source holds the word; no internal retry state.
//  Output port i: out_vld[i] = !empty[i]; out_addr/out_data show the FIFO head.
//   Pop when out_vld[i] && out_rdy[i].
//   Head is stable while out_vld[i] && !out_rdy[i].
//  Latency: word accepted at edge N is visible on out_vld at the cycle after edge N
//   (1 cycle). No bypass.
//  Ordering: per port, strict FIFO order of acceptance. No ordering between ports.
//  Simultaneous push+pop on one FIFO: occupancy unchanged, both take effect.
//  Full-FIFO case: full is registered, so a pop in the same cycle does not raise rdy.
//   Accept resumes the next cycle.
//  Pointers: log2(FIFO_DEPTH) bits plus one wrap bit.
//   full = ptrs equal with wrap bits differing; empty = ptrs fully equal.
//   Wrap-around is natural modulo.
//  Out_rdy on an empty port: ignored, no pointer change.
//  Reset asserted mid-traffic: contents discarded next edge; words in flight are lost.
//  Unused address ranges: with defaults, sel=3 (0xC0-0xFE) is unmapped and 0xFF broadcasts.
// TESTING (defaults: ports 0=0x00-3F, 1=0x40-7F, 2=0x80-BF)
//  1 Routing: send 0x10/0xAAAA, 0x50/0xBBBB, 0x90/0xCCCC with all out_rdy=1.
//    -> each appears once, next cycle, only on ports 0,1,2 respectively.
//  2 Backpressure: out_rdy[0]=0, send 5 words to 0x20.
//    -> 4 accepted; rdy=0 on the 5th, which is held.
//    Raise out_rdy[0] -> 5 words drain in order; 5th accepted the cycle after the first pop.
//  3 Broadcast: send 0xFF/0x1234.
//    -> out_vld=3'b111, all heads 0xFF/0x1234.
//    Repeat with port 2 full -> rdy=0; no port receives the word until port 2 pops.
//  4 Drop: send 0xC5 and 0xFE -> rdy=1, no out_vld, drop_cnt=2.
//    Force 65537 drops -> drop_cnt=16'hFFFF.
//  5 Concurrency and wrap: stream 20 words to port 1 with out_rdy[1] toggling every cycle.
//    -> no loss, no duplication, order preserved across pointer wrap.
//  6 Mid-op reset: fill port 0 with 3 words, assert rst for 1 cycle.
//    -> out_vld=0, drop_cnt=0, rdy=0 during rst.
//    After release, new words route normally with no stale data.

Source files
------------

// File: rtl/switch_nport.sv
// N-port address-routed packet switch: one FIFO per output port, unicast/broadcast routing,
// input backpressure and a saturating counter of unmapped (dropped) words.

module switch_nport #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned NUM_PORTS  = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          BCAST_EN   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          vld,
   output logic                          rdy,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [DATA_W-1:0]             data,
   output logic [NUM_PORTS-1:0]          out_vld,
   input  logic [NUM_PORTS-1:0]          out_rdy,
   output logic [NUM_PORTS*ADDR_W-1:0]   out_addr,
   output logic [NUM_PORTS*DATA_W-1:0]   out_data,
   output logic [15:0]                   drop_cnt
);

   localparam int unsigned PSEL_W = $clog2(NUM_PORTS);
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned PW     = AW + 1;
   localparam int unsigned EW     = ADDR_W + DATA_W;

   typedef logic [EW-1:0] entry_t;

   logic [PSEL_W-1:0]    sel;
   logic                 is_bcast;
   logic                 is_uni;
   logic                 is_drop;
   logic                 accept;
   logic [NUM_PORTS-1:0] push;
   logic [NUM_PORTS-1:0] pop;

   logic [PW-1:0]        wr_ptr_q [NUM_PORTS];
   logic [PW-1:0]        wr_ptr_d [NUM_PORTS];
   logic [PW-1:0]        rd_ptr_q [NUM_PORTS];
   logic [PW-1:0]        rd_ptr_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] full_q;
   logic [NUM_PORTS-1:0] full_d;
   logic [NUM_PORTS-1:0] empty_q;
   logic [NUM_PORTS-1:0] empty_d;
   logic [15:0]          drop_cnt_q;
   logic [15:0]          drop_cnt_d;
   entry_t               mem_q [NUM_PORTS][FIFO_DEPTH];

   // Address decode: top PSEL_W bits pick the port; all-ones may override as broadcast.
   always_comb begin
      sel      = addr[ADDR_W-1 -: PSEL_W];
      is_bcast = BCAST_EN && (addr == {ADDR_W{1'b1}});
      is_uni   = !is_bcast && ({1'b0, sel} < (PSEL_W+1)'(NUM_PORTS));
      is_drop  = !is_bcast && !is_uni;
   end

   // Acceptance looks only at registered full flags, so a same-cycle pop cannot open the gate.
   always_comb begin
      rdy = 1'b0;
      if (!rst) begin
         if (is_bcast) begin
            rdy = ~|full_q;
         end else if (is_uni) begin
            rdy = !full_q[sel];
         end else begin
            rdy = 1'b1;
         end
      end
   end

   assign accept = vld && rdy;

   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         push[i] = accept && (is_bcast || (is_uni && (sel == PSEL_W'(i))));
         pop[i]  = !rst && !empty_q[i] && out_rdy[i];
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
         full_d[i]   = (wr_ptr_d[i][AW-1:0] == rd_ptr_d[i][AW-1:0]) &&
                       (wr_ptr_d[i][AW] != rd_ptr_d[i][AW]);
         empty_d[i]  = (wr_ptr_d[i] == rd_ptr_d[i]);
      end
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && is_drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         full_q     <= '0;
         empty_q    <= '1;
         drop_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
         end
         full_q     <= full_d;
         empty_q    <= empty_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage needs no reset: heads are masked to zero whenever a FIFO is empty.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i][AW-1:0]] <= {addr, data};
         end
      end
   end

   always_comb begin
      out_vld  = '0;
      out_addr = '0;
      out_data = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         out_vld[i] = !empty_q[i];
         if (!empty_q[i]) begin
            out_addr[i*ADDR_W +: ADDR_W] = mem_q[i][rd_ptr_q[i][AW-1:0]][EW-1 -: ADDR_W];
            out_data[i*DATA_W +: DATA_W] = mem_q[i][rd_ptr_q[i][AW-1:0]][DATA_W-1:0];
         end
      end
   end

   assign drop_cnt = drop_cnt_q;

endmodule
